// File: rtl/boot_pkg.sv
// Shared types and constants for the SPART serial boot loader.
// Holds the FSM state encoding, reply bytes and checksum helper.
package boot_pkg;

    localparam logic [7:0] SYNC_DEF = 8'hA5;
    localparam logic [7:0] ACK_DEF  = 8'h06;
    localparam logic [7:0] NAK_DEF  = 8'h15;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        REPLY,
        DONE,
        ERROR
    } boot_state_t;

    function automatic logic [7:0] csum_add(
        input logic [7:0] sum,
        input logic [7:0] b
    );
        return sum + b;
    endfunction

endpackage

// File: rtl/spart_boot_ctrl.sv
// Serial boot loader: parses SYNC/LEN/data/CSUM frames from the SPART,
// writes program memory, then releases the CPU and replies ACK or NAK.
module spart_boot_ctrl
    import boot_pkg::*;
#(
    parameter int         WADDR_WIDTH = 15,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEF,
    parameter logic [7:0] ACK_BYTE    = ACK_DEF,
    parameter logic [7:0] NAK_BYTE    = NAK_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   tx_busy,
    output logic                   tx_req,
    output logic [7:0]             tx_data,
    output logic                   mem_we,
    output logic [WADDR_WIDTH-1:0] mem_waddr,
    output logic [15:0]            mem_wdata,
    output logic                   cpu_hold,
    output logic                   boot_done,
    output logic                   boot_err,
    output logic [WADDR_WIDTH:0]   words_loaded
);

    localparam int WL = WADDR_WIDTH + 1;
    // Lengths are compared at 17 bits so 2**16 stays representable.
    localparam logic [16:0] MAX_LEN = 17'(1) << WADDR_WIDTH;

    boot_state_t state;
    boot_state_t ret_state;
    logic [15:0] len;
    logic [7:0]  hi;
    logic [7:0]  sum;

    logic [15:0]   len_in;
    logic [WL-1:0] wl_next;

    assign len_in  = {len[15:8], rx_data};
    assign wl_next = words_loaded + 1'b1;

    assign mem_we    = (state == DATA_LO) && rx_valid;
    assign mem_waddr = words_loaded[WADDR_WIDTH-1:0];
    assign mem_wdata = mem_we ? {hi, rx_data} : 16'h0000;

    assign tx_req    = (state == REPLY) && !tx_busy;
    assign cpu_hold  = (state != DONE);
    assign boot_done = (state == DONE);
    assign boot_err  = (state == ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ret_state    <= IDLE;
            len          <= 16'h0000;
            hi           <= 8'h00;
            sum          <= 8'h00;
            words_loaded <= '0;
            tx_data      <= 8'h00;
        end else begin
            unique case (state)
                IDLE, ERROR: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state        <= LEN_HI;
                        sum          <= 8'h00;
                        words_loaded <= '0;
                    end
                end
                LEN_HI: begin
                    if (rx_valid) begin
                        len[15:8] <= rx_data;
                        sum       <= csum_add(sum, rx_data);
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (rx_valid) begin
                        len[7:0] <= rx_data;
                        sum      <= csum_add(sum, rx_data);
                        if ({1'b0, len_in} > MAX_LEN) begin
                            tx_data   <= NAK_BYTE;
                            ret_state <= ERROR;
                            state     <= REPLY;
                        end else if (len_in == 16'h0000) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (rx_valid) begin
                        hi    <= rx_data;
                        sum   <= csum_add(sum, rx_data);
                        state <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (rx_valid) begin
                        words_loaded <= wl_next;
                        sum          <= csum_add(sum, rx_data);
                        if (17'(wl_next) == {1'b0, len})
                            state <= CHECK;
                        else
                            state <= DATA_HI;
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        state <= REPLY;
                        if (rx_data == sum) begin
                            tx_data   <= ACK_BYTE;
                            ret_state <= DONE;
                        end else begin
                            tx_data   <= NAK_BYTE;
                            ret_state <= ERROR;
                        end
                    end
                end
                // Bytes arriving here are dropped; the host waits for the reply.
                REPLY: begin
                    if (!tx_busy)
                        state <= ret_state;
                end
                DONE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
